// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared encodings and default configuration for the UART receive controller
package uart_pkg;

  // Parity select as seen on cfg_parity / parity
  localparam logic [1:0] PAR_NONE  = 2'b00;
  localparam logic [1:0] PAR_ODD   = 2'b01;
  localparam logic [1:0] PAR_EVEN  = 2'b10;
  localparam logic [1:0] PAR_NONE2 = 2'b11;

  // Frame payload width codes (data plus parity bit)
  localparam logic [1:0] BITS_7 = 2'd0;
  localparam logic [1:0] BITS_8 = 2'd1;
  localparam logic [1:0] BITS_9 = 2'd2;

  // Baud select codes forwarded untouched to the baud rate generator
  localparam logic [1:0] BAUD_SEL_0 = 2'b00;
  localparam logic [1:0] BAUD_SEL_1 = 2'b01;
  localparam logic [1:0] BAUD_SEL_2 = 2'b10;
  localparam logic [1:0] BAUD_SEL_3 = 2'b11;

  // Controller state encoding
  localparam logic [0:0] ST_IDLE   = 1'b0;
  localparam logic [0:0] ST_ACTIVE = 1'b1;

  typedef struct packed {
    logic [1:0] parity;
    logic       stop_bit;
    logic       bits_num;
    logic [1:0] baud;
  } uart_cfg_t;

  // 8N1 at the highest baud select
  localparam uart_cfg_t CFG_DEFAULT = '{parity: PAR_NONE, stop_bit: 1'b0,
                                        bits_num: 1'b1, baud: BAUD_SEL_3};

endpackage

// File: rtl/uart_rx_ctrl_if.sv
// rtl/uart_rx_ctrl_if.sv - host read port of the UART receive controller
interface uart_rx_ctrl_if #(
  parameter int DEPTH = 4
);
  localparam int PTR_W = $clog2(DEPTH);

  logic             rd_valid;
  logic [7:0]       rd_data;
  logic             rd_perr;
  logic             rd_en;
  logic             overrun;
  logic             overrun_clr;
  logic [PTR_W:0]   fifo_level;

  // Host side: pops entries and clears the overrun flag
  modport master (
    input  rd_valid, rd_data, rd_perr, overrun, fifo_level,
    output rd_en, overrun_clr
  );

  // Controller side: presents the FIFO head and status
  modport slave (
    output rd_valid, rd_data, rd_perr, overrun, fifo_level,
    input  rd_en, overrun_clr
  );
endinterface

// File: rtl/uart_rx_fifo.sv
// rtl/uart_rx_fifo.sv - synchronous show-ahead FIFO for received frames
module uart_rx_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 9
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push,
  input  logic                       pop,
  input  logic [WIDTH-1:0]           din,
  output logic [WIDTH-1:0]           dout,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     level
);
  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W:0]   count;

  assign empty = (count == '0);
  assign full  = (count == (PTR_W+1)'(DEPTH));
  assign level = count;
  // Head is masked while empty so the read port idles at zero
  assign dout  = empty ? '0 : mem[rd_ptr];

  // Storage array; contents are only observable through a valid head
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= din;
  end

  // Pointers wrap naturally because DEPTH is a power of two
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + (PTR_W+1)'(1);
        2'b01:   count <= count - (PTR_W+1)'(1);
        default: count <= count;
      endcase
    end
  end
endmodule

// File: rtl/uart_rx_ctrl.sv
// rtl/uart_rx_ctrl.sv - UART receive control/buffering; optional error counters via UART_RX_ERR_CNT_EN
module uart_rx_ctrl
  import uart_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cfg_wr,
  input  logic [1:0]  cfg_parity,
  input  logic        cfg_stop_bit,
  input  logic        cfg_bits_num,
  input  logic [1:0]  cfg_baud,
  input  logic        rx_line,
  input  logic        rx_complete,
  input  logic [8:0]  rx_frame,
  output logic [1:0]  parity,
  output logic        stop_bit,
  output logic        bits_num,
  output logic [1:0]  baud_rate,
  output logic        cfg_pending,
  output logic        busy,
`ifdef UART_RX_ERR_CNT_EN
  output logic [7:0]  perr_count,
  output logic [7:0]  drop_count,
`endif
  uart_rx_ctrl_if.slave host
);
  localparam int PTR_W = $clog2(DEPTH);

  logic [0:0] state_q;
  uart_cfg_t  cfg_q;
  uart_cfg_t  shadow_q;
  uart_cfg_t  cfg_new;
  logic       pending_q;
  logic       overrun_q;
  logic       parity_on;
  logic       par_x;
  logic       perr;
  logic [7:0] data;
  logic       pbit;
  logic       fifo_full;
  logic       fifo_empty;
  logic       push;
  logic       pop;
  logic       drop;
  logic [8:0] head;

  assign cfg_new     = {cfg_parity, cfg_stop_bit, cfg_bits_num, cfg_baud};
  assign parity      = cfg_q.parity;
  assign stop_bit    = cfg_q.stop_bit;
  assign bits_num    = cfg_q.bits_num;
  assign baud_rate   = cfg_q.baud;
  assign cfg_pending = pending_q;
  assign busy        = (state_q == ST_ACTIVE);

  // Frame tracking: a low line in IDLE is a start bit, the receiver's completion ends it
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                                      state_q <= ST_IDLE;
    else if (state_q == ST_IDLE && !rx_line)        state_q <= ST_ACTIVE;
    else if (state_q == ST_ACTIVE && rx_complete)   state_q <= ST_IDLE;
  end

  // Config apply: immediate only when the line is quiet, otherwise shadowed until frame end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cfg_q     <= CFG_DEFAULT;
      shadow_q  <= CFG_DEFAULT;
      pending_q <= 1'b0;
    end else if (pending_q && rx_complete) begin
      cfg_q     <= cfg_wr ? cfg_new : shadow_q;
      pending_q <= 1'b0;
    end else if (cfg_wr) begin
      if (state_q == ST_IDLE && rx_line) begin
        cfg_q <= cfg_new;
      end else begin
        shadow_q  <= cfg_new;
        pending_q <= 1'b1;
      end
    end
  end

  // Data extraction and parity check against the config active at capture time
  always_comb begin
    parity_on = (cfg_q.parity == PAR_ODD) || (cfg_q.parity == PAR_EVEN);
    if (!cfg_q.bits_num) begin
      data = {1'b0, rx_frame[6:0]};
      pbit = rx_frame[7];
    end else begin
      data = rx_frame[7:0];
      pbit = rx_frame[8];
    end
    par_x = (^data) ^ pbit;
    perr  = 1'b0;
    if (parity_on) perr = (cfg_q.parity == PAR_ODD) ? ~par_x : par_x;
  end

  // A push into a full FIFO is only allowed when the head leaves in the same cycle
  assign pop  = host.rd_en && !fifo_empty;
  assign drop = rx_complete && fifo_full && !pop;
  assign push = rx_complete && !drop;

  uart_rx_fifo #(.DEPTH(DEPTH), .WIDTH(9)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .din   ({perr, data}),
    .dout  (head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (host.fifo_level)
  );

  assign host.rd_valid = !fifo_empty;
  assign host.rd_data  = head[7:0];
  assign host.rd_perr  = head[8];
  assign host.overrun  = overrun_q;

  // Sticky overrun; a new drop outranks a simultaneous clear
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                 overrun_q <= 1'b0;
    else if (drop)             overrun_q <= 1'b1;
    else if (host.overrun_clr) overrun_q <= 1'b0;
  end

`ifdef UART_RX_ERR_CNT_EN
  // Saturating error statistics, cleared together with the overrun flag
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      perr_count <= 8'd0;
      drop_count <= 8'd0;
    end else if (host.overrun_clr) begin
      perr_count <= 8'd0;
      drop_count <= 8'd0;
    end else begin
      if (push && perr && perr_count != 8'hFF) perr_count <= perr_count + 8'd1;
      if (drop && drop_count != 8'hFF)         drop_count <= drop_count + 8'd1;
    end
  end
`endif

  logic unused_ok;
  assign unused_ok = &{1'b0, PTR_W[0]};
endmodule
